// File: rtl/updown_count_tracker_pkg.sv
// Shared encodings for the up/down counter and its downstream tracker:
// event codes, tracker states, step classes and counter direction.
package updown_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      STEP_HOLD = 2'b00,
      STEP_UP   = 2'b01,
      STEP_DOWN = 2'b10,
      STEP_JUMP = 2'b11
   } step_t;

   localparam logic [1:0] EVT_WRAP_UP = 2'b00;
   localparam logic [1:0] EVT_WRAP_DN = 2'b01;
   localparam logic [1:0] EVT_JUMP    = 2'b10;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/updown_count_tracker_limit_alarm_hyst.sv
// Signed threshold alarm with set/release hysteresis; IS_HI selects the
// high-side (>=) or low-side (<=) sense.
module limit_alarm_hyst #(
   parameter int W      = 12,
   parameter int HYST   = 2,
   parameter bit IS_HI  = 1'b1
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic signed [W-1:0] val,
   input  logic signed [W-1:0] lim,
   output logic                alarm
);

   localparam logic signed [W:0] HYST_S = (W+1)'(HYST);

   // One guard bit so lim +/- HYST cannot wrap around the signed range.
   logic signed [W:0] val_x;
   logic signed [W:0] lim_x;
   logic signed [W:0] rel_x;
   logic              set_c;
   logic              clr_c;
   logic              alarm_next;

   always_comb begin
      val_x = {val[W-1], val};
      lim_x = {lim[W-1], lim};
      if (IS_HI) begin
         rel_x = lim_x - HYST_S;
         set_c = (val_x >= lim_x);
         clr_c = (val_x < rel_x);
      end else begin
         rel_x = lim_x + HYST_S;
         set_c = (val_x <= lim_x);
         clr_c = (val_x > rel_x);
      end
      alarm_next = alarm;
      if (set_c) begin
         alarm_next = 1'b1;
      end else if (clr_c) begin
         alarm_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         alarm <= 1'b0;
      end else begin
         alarm <= alarm_next;
      end
   end

endmodule

// File: rtl/updown_count_tracker.sv
// Tracks a small up/down counter: extends it with a signed wrap count,
// reports direction, limit alarms and wrap/jump events over valid/ready.
module updown_count_tracker
   import updown_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int EXT_W = 8,
   parameter int HYST  = 2
) (
   input  logic                      clk,
   input  logic                      clr_n,
   input  logic [WIDTH-1:0]          q_in,
   input  logic                      q_vld,
   input  logic                      resync,
   input  logic signed [WIDTH+EXT_W-1:0] hi_lim,
   input  logic signed [WIDTH+EXT_W-1:0] lo_lim,
   output logic signed [WIDTH+EXT_W-1:0] ext_cnt,
   output logic                      dir,
   output logic                      alarm_hi,
   output logic                      alarm_lo,
   output logic                      evt_vld,
   input  logic                      evt_rdy,
   output logic [1:0]                evt_code,
   output logic                      evt_drop
);

   localparam int W = WIDTH + EXT_W;
   localparam logic [WIDTH-1:0] Q_ZERO = '0;
   localparam logic [WIDTH-1:0] Q_MAX  = '1;
   localparam logic [WIDTH-1:0] Q_ONE  = WIDTH'(1);

   state_t           st_reg, st_next;
   logic [WIDTH-1:0] prev_reg, prev_next;
   logic [EXT_W-1:0] wrap_reg, wrap_next;
   logic             dir_reg, dir_next;
   logic             evt_vld_reg, evt_vld_next;
   logic [1:0]       evt_code_reg, evt_code_next;
   logic             evt_drop_reg, evt_drop_next;

   logic [WIDTH-1:0] delta;
   step_t            step;
   logic             gen;
   logic [1:0]       gen_code;

   always_comb begin
      delta = q_in - prev_reg;
      if (delta == Q_ZERO) begin
         step = STEP_HOLD;
      end else if (delta == Q_ONE) begin
         step = STEP_UP;
      end else if (delta == Q_MAX) begin
         step = STEP_DOWN;
      end else begin
         step = STEP_JUMP;
      end
   end

   always_comb begin
      st_next   = st_reg;
      prev_next = prev_reg;
      wrap_next = wrap_reg;
      dir_next  = dir_reg;
      gen       = 1'b0;
      gen_code  = EVT_JUMP;

      if (resync) begin
         st_next   = ST_INIT;
         wrap_next = '0;
      end else if (q_vld) begin
         prev_next = q_in;
         case (st_reg)
            ST_INIT: begin
               wrap_next = '0;
               st_next   = ST_TRACK;
            end
            ST_TRACK: begin
               case (step)
                  STEP_UP: begin
                     dir_next = DIR_UP;
                     if (prev_reg == Q_MAX) begin
                        wrap_next = wrap_reg + EXT_W'(1);
                        gen       = 1'b1;
                        gen_code  = EVT_WRAP_UP;
                     end
                  end
                  STEP_DOWN: begin
                     dir_next = DIR_DN;
                     if (prev_reg == Q_ZERO) begin
                        wrap_next = wrap_reg - EXT_W'(1);
                        gen       = 1'b1;
                        gen_code  = EVT_WRAP_DN;
                     end
                  end
                  STEP_JUMP: begin
                     wrap_next = '0;
                     gen       = 1'b1;
                     gen_code  = EVT_JUMP;
                  end
                  default: ;
               endcase
            end
            default: st_next = ST_INIT;
         endcase
      end
   end

   // Single-slot event register: a stalled slot drops newcomers, an accepted
   // slot reloads in the same cycle without a bubble.
   always_comb begin
      evt_vld_next  = evt_vld_reg;
      evt_code_next = evt_code_reg;
      evt_drop_next = evt_drop_reg;
      if (evt_vld_reg && !evt_rdy) begin
         if (gen) begin
            evt_drop_next = 1'b1;
         end
      end else begin
         evt_vld_next = gen;
         if (gen) begin
            evt_code_next = gen_code;
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         st_reg       <= ST_INIT;
         prev_reg     <= '0;
         wrap_reg     <= '0;
         dir_reg      <= 1'b0;
         evt_vld_reg  <= 1'b0;
         evt_code_reg <= 2'b00;
         evt_drop_reg <= 1'b0;
      end else begin
         st_reg       <= st_next;
         prev_reg     <= prev_next;
         wrap_reg     <= wrap_next;
         dir_reg      <= dir_next;
         evt_vld_reg  <= evt_vld_next;
         evt_code_reg <= evt_code_next;
         evt_drop_reg <= evt_drop_next;
      end
   end

   assign ext_cnt  = signed'({wrap_reg, prev_reg});
   assign dir      = dir_reg;
   assign evt_vld  = evt_vld_reg;
   assign evt_code = evt_code_reg;
   assign evt_drop = evt_drop_reg;

   limit_alarm_hyst #(.W(W), .HYST(HYST), .IS_HI(1'b1)) u_alarm_hi (
      .clk   (clk),
      .clr_n (clr_n),
      .val   (ext_cnt),
      .lim   (hi_lim),
      .alarm (alarm_hi)
   );

   limit_alarm_hyst #(.W(W), .HYST(HYST), .IS_HI(1'b0)) u_alarm_lo (
      .clk   (clk),
      .clr_n (clr_n),
      .val   (ext_cnt),
      .lim   (lo_lim),
      .alarm (alarm_lo)
   );

endmodule
